fetch_stage: RTL and testbench

Instruction-fetch stage of the 8-bit pipelined CPU. It owns the program counter, reads one byte per cycle from the instruction memory, and assembles the 16-bit IF/ID pipeline word consumed by decode: {imm[15:8], ins[7:0]}, where ins = {op[3:0], ra[1:0], rb[1:0]}. It is directly upstream of decode and of the branch, forwarding and bubble control logic. It obeys the stall (pc_en) from bubble control and the redirect select (pc_sec) from branch control.

---
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads one byte per cycle and assembles
// the 16-bit IF/ID word {imm, ins}, folding 2-byte LOADIMM into a single word.
module fetch_stage #(
   parameter logic [7:0] NOP_INS  = 8'h00,
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   output logic [7:0]  imem_addr,
   input  logic [7:0]  imem_data,
   input  logic        pc_en,
   input  logic [1:0]  pc_sec,
   input  logic [7:0]  br_target,
   input  logic [7:0]  lr_data,
   output logic [15:0] ifid_ins,
   output logic [7:0]  ifid_pc,
   output logic        ifid_valid,
   output logic [7:0]  ifid_ret
);

   localparam logic [3:0]  OP_LOADIMM = 4'hf;
   localparam logic [15:0] BUBBLE     = {8'h00, NOP_INS};

   typedef enum logic {
      FETCH,
      FETCH_IMM
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  pc, pc_nxt;
   logic [7:0]  hold, hold_nxt;
   logic [7:0]  hold_pc, hold_pc_nxt;
   logic [15:0] ifid_ins_nxt;
   logic [7:0]  ifid_pc_nxt;
   logic        ifid_valid_nxt;

   assign imem_addr = pc;
   assign ifid_ret  = ifid_pc + ((ifid_ins[7:4] == OP_LOADIMM) ? 8'd2 : 8'd1);

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         pc         <= RESET_PC;
         state      <= FETCH;
         hold       <= 8'h00;
         hold_pc    <= 8'h00;
         ifid_ins   <= BUBBLE;
         ifid_pc    <= 8'h00;
         ifid_valid <= 1'b0;
      end else begin
         pc         <= pc_nxt;
         state      <= state_nxt;
         hold       <= hold_nxt;
         hold_pc    <= hold_pc_nxt;
         ifid_ins   <= ifid_ins_nxt;
         ifid_pc    <= ifid_pc_nxt;
         ifid_valid <= ifid_valid_nxt;
      end
   end

   // Priority: redirect, then stall (all defaults hold), then normal fetch.
   always_comb begin
      pc_nxt         = pc;
      state_nxt      = state;
      hold_nxt       = hold;
      hold_pc_nxt    = hold_pc;
      ifid_ins_nxt   = ifid_ins;
      ifid_pc_nxt    = ifid_pc;
      ifid_valid_nxt = ifid_valid;
      if (pc_sec != 2'b00) begin
         pc_nxt         = (pc_sec == 2'b10) ? lr_data : br_target;
         state_nxt      = FETCH;
         ifid_ins_nxt   = BUBBLE;
         ifid_valid_nxt = 1'b0;
      end else if (pc_en) begin
         pc_nxt = pc + 8'd1;
         case (state)
            FETCH: begin
               if (imem_data[7:4] == OP_LOADIMM) begin
                  hold_nxt       = imem_data;
                  hold_pc_nxt    = pc;
                  state_nxt      = FETCH_IMM;
                  ifid_ins_nxt   = BUBBLE;
                  ifid_valid_nxt = 1'b0;
               end else begin
                  ifid_ins_nxt   = {8'h00, imem_data};
                  ifid_pc_nxt    = pc;
                  ifid_valid_nxt = 1'b1;
               end
            end
            FETCH_IMM: begin
               ifid_ins_nxt   = {imem_data, hold};
               ifid_pc_nxt    = hold_pc;
               ifid_valid_nxt = 1'b1;
               state_nxt      = FETCH;
            end
            default: state_nxt = FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random stimulus
// compared against a byte-queue reference model of instruction assembly.
module tb_fetch_stage;

   localparam logic [7:0] NOP = 8'h00;
   localparam logic [7:0] RPC = 8'h00;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  imem_addr;
   logic [7:0]  imem_data;
   logic        pc_en = 1'b1;
   logic [1:0]  pc_sec = 2'b00;
   logic [7:0]  br_target = 8'h00;
   logic [7:0]  lr_data = 8'h00;
   logic [15:0] ifid_ins;
   logic [7:0]  ifid_pc;
   logic        ifid_valid;
   logic [7:0]  ifid_ret;

   logic [7:0]  mem [256];
   assign imem_data = mem[imem_addr];

   fetch_stage #(.NOP_INS(NOP), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
      .pc_en(pc_en), .pc_sec(pc_sec), .br_target(br_target), .lr_data(lr_data),
      .ifid_ins(ifid_ins), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
      .ifid_ret(ifid_ret)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Reference model: bytes of the instruction being assembled are queued
   // until the instruction is complete (1 byte, or 2 for op 4'hf).
   logic [7:0]  m_pc;
   logic [7:0]  mq[$];
   logic [7:0]  mq_pc;
   logic [15:0] m_ins;
   logic [7:0]  m_ipc;
   logic        m_valid;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = RPC;
      mq.delete();
      m_ins = {8'h00, NOP};
      m_ipc = 8'h00;
      m_valid = 1'b0;
   endtask

   task automatic model_step(input logic en, input logic [1:0] sec,
                             input logic [7:0] bt, input logic [7:0] lr);
      if (sec != 2'b00) begin
         m_pc = (sec == 2'b10) ? lr : bt;
         mq.delete();
         m_ins = {8'h00, NOP};
         m_valid = 1'b0;
      end else if (en) begin
         if (mq.size() == 0) mq_pc = m_pc;
         mq.push_back(mem[m_pc]);
         m_pc = m_pc + 8'd1;
         if (mq[0][7:4] == 4'hf && mq.size() < 2) begin
            m_ins = {8'h00, NOP};
            m_valid = 1'b0;
         end else begin
            m_ins = {(mq.size() == 2) ? mq[1] : 8'h00, mq[0]};
            m_ipc = mq_pc;
            m_valid = 1'b1;
            mq.delete();
         end
      end
   endtask

   task automatic check_model();
      logic [7:0] ret;
      ret = m_ipc + ((m_ins[7:4] == 4'hf) ? 8'd2 : 8'd1);
      check("imem_addr", {8'h00, imem_addr}, {8'h00, m_pc});
      check("ifid_ins", ifid_ins, m_ins);
      check("ifid_pc", {8'h00, ifid_pc}, {8'h00, m_ipc});
      check("ifid_valid", {15'h0, ifid_valid}, {15'h0, m_valid});
      check("ifid_ret", {8'h00, ifid_ret}, {8'h00, ret});
   endtask

   task automatic cycle(input logic en, input logic [1:0] sec,
                        input logic [7:0] bt, input logic [7:0] lr);
      pc_en = en; pc_sec = sec; br_target = bt; lr_data = lr;
      model_step(en, sec, bt, lr);
      @(negedge clk); #1;
      check_model();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_addr"}, {8'h00, imem_addr}, {8'h00, RPC});
      check({tag, "_ins"}, ifid_ins, {8'h00, NOP});
      check({tag, "_pc"}, {8'h00, ifid_pc}, 16'h0000);
      check({tag, "_valid"}, {15'h0, ifid_valid}, 16'h0000);
   endtask

   task automatic do_reset();
      pc_en = 1'b1; pc_sec = 2'b00;
      rst = 1'b0;
      #1;
      model_reset();
      check_reset_vals("rst_async");
      @(negedge clk); #1;
      check_reset_vals("rst_held");
      rst = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      model_reset();
      #3;

      // Sequential 1-byte instructions
      mem[0] = 8'h15; mem[1] = 8'h26;
      do_reset();
      cycle(1'b1, 2'b00, 8'h00, 8'h00);
      check("seq_ins0", ifid_ins, 16'h0015);
      check("seq_valid0", {15'h0, ifid_valid}, 16'h0001);
      cycle(1'b1, 2'b00, 8'h00, 8'h00);
      check("seq_ins1", ifid_ins, 16'h0026);
      check("seq_pc1", {8'h00, ifid_pc}, 16'h0001);
      check("seq_addr", {8'h00, imem_addr}, 16'h0002);

      // LOADIMM assembly
      mem[0] = 8'hf4; mem[1] = 8'h5a; mem[2] = 8'h11;
      do_reset();
      cycle(1'b1, 2'b00, 8'h00, 8'h00);
      check("li_bubble", {15'h0, ifid_valid}, 16'h0000);
      cycle(1'b1, 2'b00, 8'h00, 8'h00);
      check("li_ins", ifid_ins, 16'h5af4);
      check("li_ret", {8'h00, ifid_ret}, 16'h0002);
      cycle(1'b1, 2'b00, 8'h00, 8'h00);
      check("li_next", ifid_ins, 16'h0011);

      // Stalls in both FETCH and FETCH_IMM at pc 03
      mem[3] = 8'hf7; mem[4] = 8'h99;
      cycle(1'b1, 2'b01, 8'h03, 8'h00);
      cycle(1'b0, 2'b00, 8'h00, 8'h00);
      cycle(1'b0, 2'b00, 8'h00, 8'h00);
      check("stall_f_addr", {8'h00, imem_addr}, 16'h0003);
      cycle(1'b1, 2'b00, 8'h00, 8'h00);
      cycle(1'b0, 2'b00, 8'h00, 8'h00);
      cycle(1'b0, 2'b00, 8'h00, 8'h00);
      check("stall_fi_addr", {8'h00, imem_addr}, 16'h0004);
      cycle(1'b1, 2'b00, 8'h00, 8'h00);
      check("stall_li_ins", ifid_ins, 16'h99f7);
      check("stall_li_pc", {8'h00, ifid_pc}, 16'h0003);

      // Redirect in FETCH_IMM with simultaneous stall, then return via lr
      mem[5] = 8'hf2; mem[8'h40] = 8'h3c;
      cycle(1'b1, 2'b00, 8'h00, 8'h00);
      cycle(1'b0, 2'b01, 8'h40, 8'h00);
      check("redir_addr", {8'h00, imem_addr}, 16'h0040);
      check("redir_valid", {15'h0, ifid_valid}, 16'h0000);
      cycle(1'b1, 2'b00, 8'h00, 8'h00);
      check("redir_ins", ifid_ins, 16'h003c);
      cycle(1'b1, 2'b10, 8'h00, 8'h07);
      check("ret_addr", {8'h00, imem_addr}, 16'h0007);
      cycle(1'b1, 2'b11, 8'h22, 8'h07);
      check("sec11_addr", {8'h00, imem_addr}, 16'h0022);

      // LOADIMM across the PC wrap
      mem[8'hff] = 8'hf1; mem[0] = 8'hcc;
      cycle(1'b1, 2'b01, 8'hff, 8'h00);
      cycle(1'b1, 2'b00, 8'h00, 8'h00);
      cycle(1'b1, 2'b00, 8'h00, 8'h00);
      check("wrap_ins", ifid_ins, 16'hccf1);
      check("wrap_pc", {8'h00, ifid_pc}, 16'h00ff);
      check("wrap_ret", {8'h00, ifid_ret}, 16'h0001);
      check("wrap_addr", {8'h00, imem_addr}, 16'h0001);

      // Asynchronous reset while in FETCH_IMM
      mem[8'h10] = 8'hf9; mem[0] = 8'h21; mem[1] = 8'h32;
      cycle(1'b1, 2'b01, 8'h10, 8'h00);
      cycle(1'b1, 2'b00, 8'h00, 8'h00);
      #2;
      do_reset();
      cycle(1'b1, 2'b00, 8'h00, 8'h00);
      check("post_rst_ins", ifid_ins, 16'h0021);
      cycle(1'b1, 2'b00, 8'h00, 8'h00);

      // Random traffic against the model
      for (int i = 0; i < 256; i++)
         mem[i] = ($urandom_range(0, 3) == 0) ? {4'hf, 4'($urandom)} : 8'($urandom);
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         logic       en;
         logic [1:0] sec;
         en  = ($urandom_range(0, 4) != 0);
         sec = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         if ($urandom_range(0, 299) == 0) do_reset();
         cycle(en, sec, 8'($urandom), 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
